// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data RAM arbiter.
//   arb_state_t : ARB (normal arbitration) / LOCK (loader owns the RAM port)
//   rd_tag_t    : which reader, if any, owns the read data returning next cycle
package mem_arb_pkg;

  localparam int unsigned DEF_DW = 24;
  localparam int unsigned DEF_AW = 24;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_DISP = 2'd2
  } rd_tag_t;

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Saturating starvation counter for the display requester.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   inc      : display is requesting but was denied this cycle
//   clr      : display granted or not requesting; has priority over inc
//   at_max   : counter has reached MAX_WAIT
module mem_arb_wait_ctr #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q;

  assign at_max = (cnt_q == CW'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data RAM arbiter for the memory stage (cpu), display reader (disp)
// and GPIO image loader (load). One grant per cycle; read data returns one cycle
// after the grant with a per-requester valid.
// Ports:
//   clk, rst                               : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt       : memory-stage access
//   cpu_stall                              : cpu_req & ~cpu_gnt, to hazard unit
//   cpu_rvalid/cpu_rdata                   : cpu read return
//   disp_req/addr -> disp_gnt              : display read request
//   disp_rvalid/disp_rdata                 : display read return
//   load_req/lock/addr/wdata -> load_gnt   : loader write, lock holds the port
//   ram_addr/ram_wdata/ram_we, ram_q       : RAM macro interface
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          load_req,
  input  logic          load_lock,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_wdata,
  output logic          load_gnt,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  arb_state_t    state_q;
  logic          ptr_q;    // 0: disp wins the next disp/load tie, 1: load wins
  rd_tag_t       tag_q;
  logic [AW-1:0] addr_q;   // last granted address, held on idle cycles
  logic [DW-1:0] wdata_q;
  logic          at_max;

  mem_arb_wait_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (disp_req & ~disp_gnt),
    .clr   (~disp_req | disp_gnt),
    .at_max(at_max)
  );

  // Grants are gated by rst so nothing reaches the RAM while in reset.
  always_comb begin
    cpu_gnt  = 1'b0;
    disp_gnt = 1'b0;
    load_gnt = 1'b0;
    if (!rst) begin
      if (state_q == LOCK) begin
        load_gnt = load_req;
      end else if (disp_req && at_max) begin
        disp_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (disp_req && load_req) begin
        load_gnt = ptr_q;
        disp_gnt = ~ptr_q;
      end else begin
        disp_gnt = disp_req;
        load_gnt = load_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;

  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    ram_we    = 1'b0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
    end else if (disp_gnt) begin
      ram_addr  = disp_addr;
    end else if (load_gnt) begin
      ram_addr  = load_addr;
      ram_wdata = load_wdata;
      ram_we    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= 1'b0;
      tag_q   <= TAG_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        ARB:     if (load_gnt && load_lock) state_q <= LOCK;
        LOCK:    if ((load_gnt && !load_lock) || !load_req) state_q <= ARB;
        default: state_q <= ARB;
      endcase

      if (disp_gnt) begin
        ptr_q <= 1'b1;
      end else if (load_gnt) begin
        ptr_q <= 1'b0;
      end

      if (cpu_gnt || load_gnt) begin
        addr_q  <= ram_addr;
        wdata_q <= ram_wdata;
      end else if (disp_gnt) begin
        addr_q  <= ram_addr;
      end

      if (cpu_gnt && !cpu_we) begin
        tag_q <= TAG_CPU;
      end else if (disp_gnt) begin
        tag_q <= TAG_DISP;
      end else begin
        tag_q <= TAG_NONE;
      end
    end
  end

  assign cpu_rvalid  = (tag_q == TAG_CPU);
  assign disp_rvalid = (tag_q == TAG_DISP);
  assign cpu_rdata   = ram_q;
  assign disp_rdata  = ram_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios followed by a
// randomized run, all checked against a cycle-level behavioural model and a
// simple RAM model attached to the RAM port.
module tb_data_mem_arbiter;

  localparam int unsigned DW       = 24;
  localparam int unsigned AW       = 24;
  localparam int unsigned MAX_WAIT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          disp_req, disp_gnt, disp_rvalid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          load_req, load_lock, load_gnt;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_wdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  data_mem_arbiter #(
    .DW(DW), .AW(AW), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .load_req(load_req), .load_lock(load_lock), .load_addr(load_addr),
    .load_wdata(load_wdata), .load_gnt(load_gnt),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 16) return 24'hABCDEF;
    return DW'((i * 32'h010203) ^ 32'h5A5A5A);
  endfunction

  // RAM model on the DUT's RAM port (synchronous write, registered read).
  logic          preload;
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else begin
      if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
      ram_q <= ram[ram_addr[7:0]];
    end
  end

  int n_chk, n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Behavioural model state.
  logic          m_lock;
  logic          m_load_next;  // load wins the next disp/load tie
  int            m_wait;
  int            m_tag;        // 0 none, 1 cpu, 2 disp
  logic [DW-1:0] m_exp_rd;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_wdata;
  logic [DW-1:0] mmem [256];
  logic          l_cg, l_dg, l_lg;  // model grants of the last cycle
  int            g_cpu, g_disp, g_load, g_stall;

  task automatic model_reset();
    m_lock = 1'b0; m_load_next = 1'b0; m_wait = 0; m_tag = 0;
    m_last_addr = '0; m_last_wdata = '0;
    g_cpu = 0; g_disp = 0; g_load = 0; g_stall = 0;
  endtask

  // Check one cycle's outputs against the model, then advance one clock.
  task automatic cycle();
    logic e_cg, e_dg, e_lg, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    #3;
    e_cg = 1'b0; e_dg = 1'b0; e_lg = 1'b0;
    if (m_lock) e_lg = load_req;
    else if (disp_req && m_wait == MAX_WAIT) e_dg = 1'b1;
    else if (cpu_req) e_cg = 1'b1;
    else if (disp_req && load_req) begin
      e_lg = m_load_next; e_dg = !m_load_next;
    end else begin
      e_dg = disp_req; e_lg = load_req;
    end
    e_addr = m_last_addr; e_wd = m_last_wdata; e_we = 1'b0;
    if (e_cg) begin e_addr = cpu_addr; e_wd = cpu_wdata; e_we = cpu_we; end
    if (e_dg) e_addr = disp_addr;
    if (e_lg) begin e_addr = load_addr; e_wd = load_wdata; e_we = 1'b1; end

    check("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
    check("disp_gnt", 32'(disp_gnt), 32'(e_dg));
    check("load_gnt", 32'(load_gnt), 32'(e_lg));
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cg));
    check("ram_we", 32'(ram_we), 32'(e_we));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    if (e_we) check("ram_wdata", 32'(ram_wdata), 32'(e_wd));
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(m_tag == 1));
    check("disp_rvalid", 32'(disp_rvalid), 32'(m_tag == 2));
    if (m_tag == 1) check("cpu_rdata", 32'(cpu_rdata), 32'(m_exp_rd));
    if (m_tag == 2) check("disp_rdata", 32'(disp_rdata), 32'(m_exp_rd));

    g_cpu += int'(cpu_gnt); g_disp += int'(disp_gnt); g_load += int'(load_gnt);
    g_stall += int'(cpu_stall);

    m_tag = (e_cg && !cpu_we) ? 1 : (e_dg ? 2 : 0);
    m_exp_rd = mmem[e_addr[7:0]];
    if (e_we) mmem[e_addr[7:0]] = e_wd;
    if (disp_req && !e_dg) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    else m_wait = 0;
    if (e_dg) m_load_next = 1'b1;
    if (e_lg) m_load_next = 1'b0;
    if (!m_lock) m_lock = e_lg && load_lock;
    else if ((e_lg && !load_lock) || !load_req) m_lock = 1'b0;
    if (e_cg || e_dg || e_lg) m_last_addr = e_addr;
    if (e_cg || e_lg) m_last_wdata = e_wd;
    l_cg = e_cg; l_dg = e_dg; l_lg = e_lg;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    disp_req = 0; disp_addr = '0;
    load_req = 0; load_lock = 0; load_addr = '0; load_wdata = '0;
  endtask

  // Hold reset for one cycle with whatever requests are driven; everything must be quiet.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_disp_gnt", 32'(disp_gnt), 32'd0);
    check("rst_load_gnt", 32'(load_gnt), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
    @(posedge clk); #1;
    check("rst_disp_rvalid_hold", 32'(disp_rvalid), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    for (int i = 0; i < 256; i++) mmem[i] = init_val(i);
    preload = 1'b1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    preload = 1'b0;
    do_reset();

    // cpu read of preloaded location
    cpu_req = 1; cpu_addr = 24'h000010;
    cycle();
    cpu_req = 0;
    #1;
    check("s1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("s1_cpu_rdata", 32'(cpu_rdata), 32'hABCDEF);
    check("s1_disp_rvalid", 32'(disp_rvalid), 32'd0);
    cycle();

    // all three request continuously: disp only via starvation override
    do_reset();
    cpu_req = 1; cpu_addr = 24'h3; disp_req = 1; disp_addr = 24'h4;
    load_req = 1; load_addr = 24'h5; load_wdata = 24'h111111;
    for (int i = 0; i < 18; i++) cycle();
    check("s2_cpu_grants", 32'(g_cpu), 32'd16);
    check("s2_disp_grants", 32'(g_disp), 32'd2);
    check("s2_load_grants", 32'(g_load), 32'd0);
    check("s2_stalls", 32'(g_stall), 32'd2);
    idle_inputs();

    // disp and load alternate while cpu idle
    do_reset();
    disp_req = 1; disp_addr = 24'h7; load_req = 1; load_addr = 24'h8; load_wdata = 24'h222222;
    #1;
    check("s3_first_disp", 32'(disp_gnt), 32'd1);
    for (int i = 0; i < 8; i++) cycle();
    check("s3_disp_grants", 32'(g_disp), 32'd4);
    check("s3_load_grants", 32'(g_load), 32'd4);
    idle_inputs();

    // locked four-beat load burst; cpu requests from beat 2 on
    do_reset();
    load_req = 1; load_lock = 1; load_addr = 24'h30; load_wdata = 24'h0A0A0A;
    cycle();
    cpu_req = 1; cpu_addr = 24'h31;
    for (int b = 2; b <= 4; b++) begin
      load_addr = AW'(24'h30 + b); load_wdata = DW'(b);
      load_lock = (b != 4);
      cycle();
    end
    check("s4_stalls", 32'(g_stall), 32'd3);
    check("s4_load_grants", 32'(g_load), 32'd4);
    load_req = 0; load_lock = 0;
    #1;
    check("s4_cpu_gnt_after", 32'(cpu_gnt), 32'd1);
    cycle();
    idle_inputs();

    // write then read-after-write through the display port
    cpu_req = 1; cpu_we = 1; cpu_addr = 24'h20; cpu_wdata = 24'h123456;
    cycle();
    idle_inputs();
    disp_req = 1; disp_addr = 24'h20;
    cycle();
    disp_req = 0;
    #1;
    check("s5_disp_rvalid", 32'(disp_rvalid), 32'd1);
    check("s5_disp_rdata", 32'(disp_rdata), 32'h123456);
    cycle();

    // reset right after a display read grant: the read is lost
    disp_req = 1; disp_addr = 24'h5;
    cycle();
    disp_req = 0; cpu_req = 1; cpu_addr = 24'h9; load_req = 1; load_addr = 24'h9;
    do_reset();
    idle_inputs();
    cycle();

    // randomized traffic; requesters hold until granted
    for (int i = 0; i < 600; i++) begin
      if (!cpu_req || l_cg) begin
        cpu_req = ($urandom_range(0, 2) == 0); cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = DW'($urandom);
      end
      if (!disp_req || l_dg) begin
        disp_req = ($urandom_range(0, 1) == 1); disp_addr = AW'($urandom_range(0, 15));
      end
      if (!load_req || l_lg) begin
        load_req = ($urandom_range(0, 2) == 0); load_lock = ($urandom_range(0, 1) == 1);
        load_addr = AW'($urandom_range(0, 15)); load_wdata = DW'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
